bf_core_io: RTL and testbench
=============================

// Module: bf_core_io
// PURPOSE
//  Second-generation brainfuck execution core. Parametrised cell/address widths, hardware loop
//  stack for single-step ']' back-jumps, '.'/',' I/O over valid/ready streams, comment skipping
//  and explicit halt/error status. Sits between a code RAM, an array RAM and a host/UART bridge.
// PARAMETERS
//  CODE_AW     9   code RAM address width (program <= 2**CODE_AW bytes)
//  ARRAY_AW    9   array RAM address width (pointer wraps modulo 2**ARRAY_AW)
//  CELL_W      8   array cell width; '+'/'-' wrap modulo 2**CELL_W; I/O uses cell[7:0] (CELL_W>=8)
//  STACK_DEPTH 16  loop stack entries (max '[' nesting)
// PORTS
//  clk          in   1         clock, all logic on rising edge
//  reset        in   1         synchronous, active-high
//  code_data    in   8         code RAM read data; valid 1 cycle after code_addr changes
//  code_addr    out  CODE_AW   code RAM address (program counter)
//  array_rdata  in   CELL_W    array RAM read data; valid 1 cycle after array_addr/write
//  array_addr   out  ARRAY_AW  data pointer
//  array_wdata  out  CELL_W    array write data
//  array_we     out  1         array write strobe, one cycle per write
//  out_data     out  8         '.' output byte
//  out_valid    out  1         out_data valid; held until out_ready
//  out_ready    in   1         sink accepts out_data
//  in_data      in   8         ',' input byte
//  in_valid     in   1         in_data valid
//  in_ready     out  1         core waiting for ','
//  halted       out  1         program finished or error; sticky until reset
//  error        out  2         0 none, 1 stack overflow, 2 unmatched ']', 3 unmatched '['
// BEHAVIOUR
//  Reset: code_addr=0, array_addr=0, array_wdata=0, array_we=0, out_data=0, out_valid=0,
//   in_ready=0, halted=0, error=0, stack emptied, state=FETCH. Reset mid-op aborts any handshake.
//  States: FETCH (1 cycle, RAM latency) -> EXEC; SCAN_F/SCAN_E pair for forward skip;
//   OUT_WAIT; IN_WAIT; HALT (absorbing, all strobes 0).
//  EXEC by code_data, every path ends code_addr+=1 -> FETCH unless noted:
//   '+'/'-': array_wdata=array_rdata+/-1 (wrap), array_we=1 for this cycle only.
//   '>'/'<': array_addr+/-1 modulo 2**ARRAY_AW.
//   '[': cell!=0 -> push code_addr; full stack -> error=1, HALT.
//        cell==0 -> depth=0, enter SCAN_F (skip past matching ']').
//   ']': stack empty -> error=2, HALT. cell!=0 -> code_addr=top+1, no pop. cell==0 -> pop.
//   '.': out_data=array_rdata[7:0], out_valid=1 -> OUT_WAIT.
//   ',': in_ready=1 -> IN_WAIT.
//   8'h00: HALT, error=0. Any other byte: comment, advance only.
//  SCAN: 2 cycles/byte; '[' depth+1; ']' with depth>0 depth-1, depth==0 -> advance past it,
//   FETCH; 8'h00 -> error=3, HALT. depth width CODE_AW.
//  OUT_WAIT: out_data stable; out_valid&out_ready in same cycle -> out_valid=0, advance.
//  IN_WAIT: in_valid&in_ready -> array_wdata={0,in_data}, array_we=1, in_ready=0, advance.
//  Code end: code_addr advancing from 2**CODE_AW-1 -> HALT, error=0 (no wrap execution).
//  Throughput: 2 cycles per non-I/O instruction incl. taken ']' jump; array RAM must return
//   written data on the read following the write.
//  halted=1 exactly in HALT; error stable once set.
// STRUCTURE
//  bf_pkg: opcode byte constants, state enum, error code constants (shared with successors).
//  Sub-module bf_loop_stack: LIFO, params DEPTH/W=CODE_AW; push/pop/top/empty/full, sync
//   active-high reset clears pointer. Core FSM, pointer, I/O regs in bf_core_io.
// TESTING (behavioural code/array RAMs, 1-cycle read)
//  "+++." -> one out byte 8'h03; halted=1, error=0 after 8'h00 terminator.
//  "-." CELL_W=8 -> out 8'hFF; "<+" -> array[2**ARRAY_AW-1]=1 (pointer wrap).
//  "++[->+<]>." -> out 8'h02; taken ']' costs exactly 2 cycles (cycle count check).
//  "[+[+]x]." cell=0 -> nested skip, out 8'h00; "[+" -> error=3; "]" -> error=2.
//  STACK_DEPTH=2, "+[[[" -> error=1, halted, no further array_we.
//  ",+." in_valid after 5 idle cycles, in_data=8'h41, out_ready low 3 cycles -> out 8'h42,
//   out_data stable while stalled; reset during OUT_WAIT -> out_valid=0 next cycle.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck core family: opcode bytes, FSM states and error codes.
package bf_pkg;

    localparam logic [7:0] OP_INC   = 8'h2B;  // '+'
    localparam logic [7:0] OP_DEC   = 8'h2D;  // '-'
    localparam logic [7:0] OP_RIGHT = 8'h3E;  // '>'
    localparam logic [7:0] OP_LEFT  = 8'h3C;  // '<'
    localparam logic [7:0] OP_OPEN  = 8'h5B;  // '['
    localparam logic [7:0] OP_CLOSE = 8'h5D;  // ']'
    localparam logic [7:0] OP_OUT   = 8'h2E;  // '.'
    localparam logic [7:0] OP_IN    = 8'h2C;  // ','
    localparam logic [7:0] OP_END   = 8'h00;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_EXEC     = 3'd1,
        ST_SCAN_F   = 3'd2,
        ST_SCAN_E   = 3'd3,
        ST_OUT_WAIT = 3'd4,
        ST_IN_WAIT  = 3'd5,
        ST_HALT     = 3'd6
    } bf_state_e;

    localparam logic [1:0] ERR_NONE            = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW        = 2'd1;
    localparam logic [1:0] ERR_UNMATCHED_CLOSE = 2'd2;
    localparam logic [1:0] ERR_UNMATCHED_OPEN  = 2'd3;

endpackage

// File: rtl/bf_core_io_if.sv
// Byte streams between the core and the host bridge: '.' output and ',' input.
// Handshake: a byte moves on a rising edge where valid and ready are both high; the side
// driving valid keeps valid and data stable until that edge.
interface bf_core_io_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output out_data, out_valid, in_ready,
        input  out_ready, in_data, in_valid
    );

    modport slave (
        input  out_data, out_valid, in_ready,
        output out_ready, in_data, in_valid
    );

endinterface

// File: rtl/bf_loop_stack.sv
// LIFO of '[' addresses; top is the most recently pushed entry, push/pop ignored when full/empty.
module bf_loop_stack #(
    parameter int DEPTH = 16,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] count;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;

    assign wr_idx  = count[IW-1:0];
    assign top_idx = count[IW-1:0] - IW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == PW'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (push && !full) begin
            mem[wr_idx] <= push_data;
            count       <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/bf_core_io.sv
// Brainfuck execution core: FETCH/EXEC pipeline over 1-cycle code and array RAMs, hardware
// loop stack for single-step back-jumps, stream I/O, forward skip scanning and halt/error status.
module bf_core_io
    import bf_pkg::*;
#(
    parameter int CODE_AW     = 9,
    parameter int ARRAY_AW    = 9,
    parameter int CELL_W      = 8,
    parameter int STACK_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          code_data,
    output logic [CODE_AW-1:0]  code_addr,
    input  logic [CELL_W-1:0]   array_rdata,
    output logic [ARRAY_AW-1:0] array_addr,
    output logic [CELL_W-1:0]   array_wdata,
    output logic                array_we,
    bf_core_io_if.master        io,
    output logic                halted,
    output logic [1:0]          error,
    output bf_state_e           state_dbg
);

    bf_state_e          state;
    logic [CODE_AW-1:0] depth;
    logic               cell_zero;
    logic               code_end;
    logic               stk_push;
    logic               stk_pop;
    logic               stk_empty;
    logic               stk_full;
    logic [CODE_AW-1:0] stk_top;

    assign cell_zero = (array_rdata == '0);
    assign code_end  = &code_addr;
    assign halted    = (state == ST_HALT);
    assign state_dbg = state;

    // The loop stays on the stack while it repeats; it is popped only when ']' falls through.
    assign stk_push = (state == ST_EXEC) && (code_data == OP_OPEN) && !cell_zero && !stk_full;
    assign stk_pop  = (state == ST_EXEC) && (code_data == OP_CLOSE) && cell_zero && !stk_empty;

    bf_loop_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (CODE_AW)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (code_addr),
        .top       (stk_top),
        .empty     (stk_empty),
        .full      (stk_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_FETCH;
            code_addr    <= '0;
            array_addr   <= '0;
            array_wdata  <= '0;
            array_we     <= 1'b0;
            io.out_data  <= '0;
            io.out_valid <= 1'b0;
            io.in_ready  <= 1'b0;
            error        <= ERR_NONE;
            depth        <= '0;
        end else begin
            array_we <= 1'b0;
            case (state)
                ST_FETCH: state <= ST_EXEC;

                ST_EXEC: begin
                    case (code_data)
                        OP_INC: begin
                            array_wdata <= array_rdata + 1'b1;
                            array_we    <= 1'b1;
                        end
                        OP_DEC: begin
                            array_wdata <= array_rdata - 1'b1;
                            array_we    <= 1'b1;
                        end
                        OP_RIGHT: array_addr <= array_addr + 1'b1;
                        OP_LEFT:  array_addr <= array_addr - 1'b1;
                        default:  ;
                    endcase

                    if (code_data == OP_END) begin
                        state <= ST_HALT;
                    end else if (code_data == OP_OPEN && !cell_zero && stk_full) begin
                        error <= ERR_OVERFLOW;
                        state <= ST_HALT;
                    end else if (code_data == OP_CLOSE && stk_empty) begin
                        error <= ERR_UNMATCHED_CLOSE;
                        state <= ST_HALT;
                    end else if (code_data == OP_CLOSE && !cell_zero) begin
                        // Jump straight to the first body instruction so a taken ']' costs 2 cycles.
                        code_addr <= stk_top + 1'b1;
                        state     <= ST_FETCH;
                    end else if (code_data == OP_OUT) begin
                        io.out_data  <= array_rdata[7:0];
                        io.out_valid <= 1'b1;
                        state        <= ST_OUT_WAIT;
                    end else if (code_data == OP_IN) begin
                        io.in_ready <= 1'b1;
                        state       <= ST_IN_WAIT;
                    end else if (code_end) begin
                        state <= ST_HALT;
                    end else begin
                        code_addr <= code_addr + 1'b1;
                        depth     <= '0;
                        state     <= (code_data == OP_OPEN && cell_zero) ? ST_SCAN_F : ST_FETCH;
                    end
                end

                ST_SCAN_F: state <= ST_SCAN_E;

                ST_SCAN_E: begin
                    if (code_data == OP_END) begin
                        error <= ERR_UNMATCHED_OPEN;
                        state <= ST_HALT;
                    end else if (code_end) begin
                        state <= ST_HALT;
                    end else begin
                        code_addr <= code_addr + 1'b1;
                        state     <= ST_SCAN_F;
                        if (code_data == OP_OPEN) begin
                            depth <= depth + 1'b1;
                        end else if (code_data == OP_CLOSE) begin
                            if (depth == '0) state <= ST_FETCH;
                            else             depth <= depth - 1'b1;
                        end
                    end
                end

                ST_OUT_WAIT: begin
                    if (io.out_ready) begin
                        io.out_valid <= 1'b0;
                        if (code_end) state <= ST_HALT;
                        else begin
                            code_addr <= code_addr + 1'b1;
                            state     <= ST_FETCH;
                        end
                    end
                end

                ST_IN_WAIT: begin
                    if (io.in_valid) begin
                        array_wdata <= CELL_W'(io.in_data);
                        array_we    <= 1'b1;
                        io.in_ready <= 1'b0;
                        if (code_end) state <= ST_HALT;
                        else begin
                            code_addr <= code_addr + 1'b1;
                            state     <= ST_FETCH;
                        end
                    end
                end

                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_core_io.sv
// Directed bench for bf_core_io: table of small programs with hand-computed outputs, cycle
// counts, error codes and cell contents, plus stream stall and reset-abort sequences.
module tb_bf_core_io;
    import bf_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] code_data;
    logic [8:0] code_addr;
    logic [7:0] array_rdata;
    logic [8:0] array_addr;
    logic [7:0] array_wdata;
    logic       array_we;
    logic       halted;
    logic [1:0] error;
    bf_state_e  state_dbg;

    bf_core_io_if io_bus ();

    bf_core_io #(
        .CODE_AW     (9),
        .ARRAY_AW    (9),
        .CELL_W      (8),
        .STACK_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .code_data   (code_data),
        .code_addr   (code_addr),
        .array_rdata (array_rdata),
        .array_addr  (array_addr),
        .array_wdata (array_wdata),
        .array_we    (array_we),
        .io          (io_bus),
        .halted      (halted),
        .error       (error),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    // Behavioural RAMs with 1-cycle read; the array RAM is write-first.
    logic [7:0] code_mem [512];
    logic [7:0] arr_mem  [512];

    always @(posedge clk) begin
        code_data <= code_mem[code_addr];
        if (array_we) begin
            arr_mem[array_addr] <= array_wdata;
            array_rdata         <= array_wdata;
        end else begin
            array_rdata <= arr_mem[array_addr];
        end
    end

    typedef struct {
        string      prog;
        logic [7:0] in_byte;
        int         n_out;
        logic [7:0] exp_out;
        logic [1:0] exp_err;
        int         exp_cyc;
        logic [8:0] chk_addr;
        logic [7:0] chk_val;
    } vec_t;

    vec_t       vecs [10];
    logic [7:0] exp_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         k;
    int         bad;
    int         seen;
    logic [7:0] got;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start(input string prog);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 512; i++) begin
            code_mem[9'(i)] = 8'h00;
            arr_mem[9'(i)]  = 8'h00;
        end
        for (int i = 0; i < prog.len(); i++) code_mem[9'(i)] = prog[i];
        @(posedge clk);
        @(negedge clk);
        check("reset_state",
              {code_addr, array_addr, array_wdata, array_we, io_bus.out_data,
               io_bus.out_valid, io_bus.in_ready, halted, error, state_dbg},
              {9'd0, 9'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, ST_FETCH});
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int quiet_bad;
        io_bus.out_ready = 1'b1;
        io_bus.in_valid  = 1'b1;
        io_bus.in_data   = v.in_byte;
        exp_q.delete();
        if (v.n_out > 0) exp_q.push_back(v.exp_out);
        start(v.prog);
        cyc = 0;
        while (!halted && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (io_bus.out_valid && io_bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL v%0d unexpected_out: got %0h expected none", idx, io_bus.out_data);
                end else begin
                    check($sformatf("v%0d out_byte", idx), io_bus.out_data, exp_q.pop_front());
                end
            end
        end
        check($sformatf("v%0d halted", idx), halted, 1'b1);
        check($sformatf("v%0d cycles", idx), cyc, v.exp_cyc);
        check($sformatf("v%0d error", idx), error, v.exp_err);
        check($sformatf("v%0d missing_out", idx), exp_q.size(), 0);
        check($sformatf("v%0d cell", idx), arr_mem[v.chk_addr], v.chk_val);
        quiet_bad = 0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (array_we || io_bus.out_valid || io_bus.in_ready || !halted || state_dbg != ST_HALT)
                quiet_bad = 1;
        end
        check($sformatf("v%0d halt_quiet", idx), quiet_bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        io_bus.out_ready = 1'b0;
        io_bus.in_valid  = 1'b0;
        io_bus.in_data   = 8'h00;

        //            prog           in     n  out    err   cyc  addr    val
        vecs[0] = '{"+++.",        8'h00, 1, 8'h03, 2'd0, 11, 9'd0,   8'h03};
        vecs[1] = '{"-.",          8'h00, 1, 8'hFF, 2'd0, 7,  9'd0,   8'hFF};
        vecs[2] = '{"++[->+<]>.",  8'h00, 1, 8'h02, 2'd0, 33, 9'd1,   8'h02};
        vecs[3] = '{"[+[+]x].",    8'h00, 1, 8'h00, 2'd0, 19, 9'd0,   8'h00};
        vecs[4] = '{"[+",          8'h00, 0, 8'h00, 2'd3, 6,  9'd0,   8'h00};
        vecs[5] = '{"]",           8'h00, 0, 8'h00, 2'd2, 2,  9'd0,   8'h00};
        vecs[6] = '{"+[[[",        8'h00, 0, 8'h00, 2'd1, 8,  9'd0,   8'h01};
        vecs[7] = '{"<+",          8'h00, 0, 8'h00, 2'd0, 6,  9'd511, 8'h01};
        vecs[8] = '{"a+b+.",       8'h00, 1, 8'h02, 2'd0, 13, 9'd0,   8'h02};
        vecs[9] = '{",.",          8'h7F, 1, 8'h7F, 2'd0, 8,  9'd0,   8'h7F};

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Input arrives after idle cycles, output sink stalls before accepting.
        io_bus.out_ready = 1'b0;
        io_bus.in_valid  = 1'b0;
        io_bus.in_data   = 8'h00;
        start(",+.");
        k = 0;
        while (!io_bus.in_ready && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check("a_in_ready", io_bus.in_ready, 1'b1);
        bad = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (!io_bus.in_ready || array_we || state_dbg != ST_IN_WAIT) bad = 1;
        end
        check("a_idle_wait", bad, 0);
        io_bus.in_valid = 1'b1;
        io_bus.in_data  = 8'h41;
        @(posedge clk);
        @(negedge clk);
        io_bus.in_valid = 1'b0;
        check("a_in_accept", {io_bus.in_ready, array_we, array_wdata}, {1'b0, 1'b1, 8'h41});
        k = 0;
        while (!io_bus.out_valid && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check("a_out_data", {io_bus.out_valid, io_bus.out_data}, {1'b1, 8'h42});
        bad = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (!io_bus.out_valid || io_bus.out_data != 8'h42 || state_dbg != ST_OUT_WAIT) bad = 1;
        end
        check("a_out_stall", bad, 0);
        io_bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("a_out_release", io_bus.out_valid, 1'b0);
        k = 0;
        while (!halted && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check("a_halt", {halted, error}, {1'b1, 2'd0});
        check("a_cell", arr_mem[0], 8'h42);

        // Reset while an output byte is pending aborts the handshake.
        io_bus.out_ready = 1'b0;
        start("+.");
        k = 0;
        while (!io_bus.out_valid && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check("b_out_pending", {io_bus.out_valid, io_bus.out_data}, {1'b1, 8'h01});
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b_reset_abort", {io_bus.out_valid, halted, code_addr, state_dbg},
              {1'b0, 1'b0, 9'd0, ST_FETCH});
        reset = 1'b0;
        io_bus.out_ready = 1'b1;
        seen = 0;
        got  = 8'h00;
        k = 0;
        while (!halted && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (io_bus.out_valid && io_bus.out_ready) begin
                seen++;
                got = io_bus.out_data;
            end
        end
        // The array RAM is not cleared by reset, so the rerun increments the surviving 1.
        check("b_rerun_out", {seen[7:0], got}, {8'd1, 8'h02});
        check("b_rerun_halt", {halted, error}, {1'b1, 2'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
